// File: rtl/my_top_pkg.sv
// Shared UART transmitter definitions: FSM states, baud table and divisor math.
package my_top_pkg;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_START = 3'd1,
    S_DATA  = 3'd2,
    S_STOP  = 3'd3,
    S_DONE  = 3'd4
  } tx_state_t;

  localparam int DATA_BITS  = 8;
  localparam int FRAME_BITS = 10;
  localparam int DIV_W      = 13;

  localparam int BAUD_TABLE [8] = '{9600, 19200, 38400, 57600,
                                    115200, 230400, 460800, 921600};

  // Rounded clk_freq/baud, evaluated at elaboration only.
  function automatic logic [DIV_W-1:0] calc_div(input int clk_freq, input int baud);
    int q;
    q = (clk_freq + baud / 2) / baud;
    return q[DIV_W-1:0];
  endfunction

endpackage

// File: rtl/uart_baud_gen.sv
// Bit-period timer: maps the latched baud code to a divisor and ticks once per bit.
module uart_baud_gen
  import my_top_pkg::*;
#(
  parameter int CLK_FREQ = 50_000_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       i_run,
  input  logic [3:0] i_baud_code,
  output logic       o_bit_tick
);

  localparam logic [DIV_W-1:0] DIV_0 = calc_div(CLK_FREQ, BAUD_TABLE[0]);
  localparam logic [DIV_W-1:0] DIV_1 = calc_div(CLK_FREQ, BAUD_TABLE[1]);
  localparam logic [DIV_W-1:0] DIV_2 = calc_div(CLK_FREQ, BAUD_TABLE[2]);
  localparam logic [DIV_W-1:0] DIV_3 = calc_div(CLK_FREQ, BAUD_TABLE[3]);
  localparam logic [DIV_W-1:0] DIV_4 = calc_div(CLK_FREQ, BAUD_TABLE[4]);
  localparam logic [DIV_W-1:0] DIV_5 = calc_div(CLK_FREQ, BAUD_TABLE[5]);
  localparam logic [DIV_W-1:0] DIV_6 = calc_div(CLK_FREQ, BAUD_TABLE[6]);
  localparam logic [DIV_W-1:0] DIV_7 = calc_div(CLK_FREQ, BAUD_TABLE[7]);

  logic [DIV_W-1:0] w_div;
  logic [DIV_W-1:0] w_last;
  logic [DIV_W-1:0] r_cnt;

  // Codes 8..15 fall back to the slowest rate.
  always_comb begin
    w_div = DIV_0;
    case (i_baud_code)
      4'd1:    w_div = DIV_1;
      4'd2:    w_div = DIV_2;
      4'd3:    w_div = DIV_3;
      4'd4:    w_div = DIV_4;
      4'd5:    w_div = DIV_5;
      4'd6:    w_div = DIV_6;
      4'd7:    w_div = DIV_7;
      default: w_div = DIV_0;
    endcase
  end

  assign w_last     = w_div - DIV_W'(1);
  assign o_bit_tick = i_run && (r_cnt == w_last);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (!i_run || o_bit_tick) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + DIV_W'(1);
    end
  end

endmodule

// File: rtl/my_top.sv
// 8N1 UART transmitter: latches byte and baud code on request, shifts LSB first.
module my_top
  import my_top_pkg::*;
#(
  parameter int CLK_FREQ = 50_000_000
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [7:0] data,
  input  logic       send_en,
  input  logic [3:0] baud_set,
  output logic       uart_tx,
  output logic       tx_done
);

  tx_state_t r_state;
  tx_state_t w_state_next;
  logic [7:0] r_data;
  logic [3:0] r_baud;
  logic [2:0] r_idx;
  logic       r_tx;
  logic       r_done;
  logic       w_tx_next;
  logic       w_done_next;
  logic       w_load;
  logic       w_shift;
  logic       w_run;
  logic       w_bit_tick;

  assign w_run = (r_state == S_START) || (r_state == S_DATA) || (r_state == S_STOP);

  uart_baud_gen #(.CLK_FREQ(CLK_FREQ)) u_baud_gen (
    .clk         (clk),
    .rst         (reset_n),
    .i_run       (w_run),
    .i_baud_code (r_baud),
    .o_bit_tick  (w_bit_tick)
  );

  // The line value is decided one bit ahead so uart_tx can stay registered.
  always_comb begin
    w_state_next = r_state;
    w_tx_next    = r_tx;
    w_done_next  = 1'b0;
    w_load       = 1'b0;
    w_shift      = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_tx_next = 1'b1;
        if (send_en) begin
          w_load       = 1'b1;
          w_tx_next    = 1'b0;
          w_state_next = S_START;
        end
      end
      S_START: begin
        if (w_bit_tick) begin
          w_tx_next    = r_data[0];
          w_state_next = S_DATA;
        end
      end
      S_DATA: begin
        if (w_bit_tick) begin
          w_shift = 1'b1;
          if (r_idx == 3'(DATA_BITS - 1)) begin
            w_tx_next    = 1'b1;
            w_state_next = S_STOP;
          end else begin
            w_tx_next = r_data[1];
          end
        end
      end
      S_STOP: begin
        if (w_bit_tick) begin
          w_tx_next    = 1'b1;
          w_done_next  = 1'b1;
          w_state_next = S_DONE;
        end
      end
      S_DONE: begin
        w_tx_next    = 1'b1;
        w_state_next = S_IDLE;
      end
      default: begin
        w_tx_next    = 1'b1;
        w_state_next = S_IDLE;
      end
    endcase
  end

  // reset_n is active-high despite its name.
  always_ff @(posedge clk or posedge reset_n) begin
    if (reset_n) begin
      r_state <= S_IDLE;
      r_data  <= '0;
      r_baud  <= '0;
      r_idx   <= '0;
      r_tx    <= 1'b1;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_next;
      r_tx    <= w_tx_next;
      r_done  <= w_done_next;
      if (w_load) begin
        r_data <= data;
        r_baud <= baud_set;
        r_idx  <= '0;
      end else if (w_shift) begin
        r_data <= {1'b0, r_data[7:1]};
        r_idx  <= r_idx + 3'd1;
      end
    end
  end

  assign uart_tx = r_tx;
  assign tx_done = r_done;

endmodule

// File: tb/tb_my_top.sv
// Directed bench for the 8N1 UART transmitter at 50 MHz.
module tb_my_top;
  import my_top_pkg::*;

  logic       clk;
  logic       reset_n;
  logic [7:0] data;
  logic       send_en;
  logic [3:0] baud_set;
  logic       uart_tx;
  logic       tx_done;

  int n_checks;
  int n_errors;

  my_top #(.CLK_FREQ(50_000_000)) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .data     (data),
    .send_en  (send_en),
    .baud_set (baud_set),
    .uart_tx  (uart_tx),
    .tx_done  (tx_done)
  );

  // clock / reset
  initial clk = 1'b0;
  always #10 clk = ~clk;

  initial begin
    #4ms;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1, "timeout");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Returns the number of edges until the line drops (the start edge).
  task automatic wait_start(input int limit, output int n);
    n = 0;
    while (n < limit) begin
      step();
      n++;
      if (uart_tx === 1'b0) return;
    end
    n = limit + 1;
  endtask

  // Called 1 ns after the start edge; checks every cycle through DONE and back to IDLE.
  task automatic run_frame(input logic [7:0] d, input int div, input bit drop,
                           input int chg_at, input string tag);
    logic [9:0] bits;
    logic       exp_tx;
    int         e_line;
    int         n_done;
    bits   = {1'b1, d, 1'b0};
    e_line = 0;
    n_done = 0;
    for (int c = 0; c <= FRAME_BITS * div + 1; c++) begin
      if (c > 0) step();
      exp_tx = (c < FRAME_BITS * div) ? bits[c / div] : 1'b1;
      if (uart_tx !== exp_tx) e_line++;
      if (tx_done === 1'b1) n_done++;
      if (c < FRAME_BITS * div && (c % div) == 0)
        check($sformatf("%s_bit%0d", tag, c / div), 32'(uart_tx), 32'(exp_tx));
      if (c == FRAME_BITS * div) begin
        check({tag, "_done_pulse"}, 32'(tx_done), 32'd1);
        if (drop) send_en = 1'b0;
      end
      if (c == chg_at) begin
        data     = ~d;
        baud_set = 4'd7;
      end
    end
    check({tag, "_line_errs"}, 32'(e_line), 32'd0);
    check({tag, "_done_count"}, 32'(n_done), 32'd1);
  endtask

  // Measures start-bit and data-bit-0 widths for byte 0x01, then aborts by reset.
  task automatic measure(input logic [3:0] code, input int div, input string tag);
    int n;
    data     = 8'h01;
    baud_set = code;
    send_en  = 1'b1;
    wait_start(50, n);
    check({tag, "_gap"}, 32'(n), 32'd1);
    send_en = 1'b0;
    n = 0;
    do begin step(); n++; end while (uart_tx === 1'b0 && n < 6000);
    check({tag, "_start_width"}, 32'(n), 32'(div));
    n = 0;
    do begin step(); n++; end while (uart_tx === 1'b1 && n < 6000);
    check({tag, "_bit0_width"}, 32'(n), 32'(div));
    reset_n = 1'b1;
    #1;
    check({tag, "_abort_tx"}, 32'(uart_tx), 32'd1);
    step();
    reset_n = 1'b0;
  endtask

  initial begin
    int n;
    int e;
    n_checks = 0;
    n_errors = 0;
    reset_n  = 1'b1;
    data     = 8'h00;
    send_en  = 1'b0;
    baud_set = 4'd0;

    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("rst_tx", 32'(uart_tx), 32'd1);
      check("rst_done", 32'(tx_done), 32'd0);
    end
    step();

    // 0x87 at 115200, request present as reset releases
    data     = 8'h87;
    baud_set = 4'd4;
    send_en  = 1'b1;
    reset_n  = 1'b0;
    wait_start(50, n);
    check("a_gap", 32'(n), 32'd1);
    run_frame(8'h87, 434, 1'b1, -1, "a");

    e = 0;
    repeat (5000) begin
      step();
      if (uart_tx !== 1'b1 || tx_done !== 1'b0) e++;
    end
    check("idle_line", 32'(e), 32'd0);

    // 0x48 twice back to back; second frame has inputs disturbed mid-frame
    data     = 8'h48;
    baud_set = 4'd4;
    send_en  = 1'b1;
    wait_start(50, n);
    check("b_gap", 32'(n), 32'd1);
    run_frame(8'h48, 434, 1'b0, -1, "b");
    wait_start(50, n);
    check("c_b2b_gap", 32'(n), 32'd1);
    run_frame(8'h48, 434, 1'b1, 3 * 434 + 100, "c");

    measure(4'd0, 5208, "w0");
    measure(4'd7, 54, "w7");
    measure(4'd12, 5208, "w12");

    // abort during data bit 3 (0xA5 bit3 = 0), then a fresh frame
    data     = 8'hA5;
    baud_set = 4'd4;
    send_en  = 1'b1;
    wait_start(50, n);
    check("r_gap", 32'(n), 32'd1);
    repeat (4 * 434 + 200) @(posedge clk);
    #1;
    check("r_pre_d3", 32'(uart_tx), 32'd0);
    #5;
    reset_n = 1'b1;
    #1;
    check("r_async_tx", 32'(uart_tx), 32'd1);
    check("r_async_done", 32'(tx_done), 32'd0);
    repeat (3) @(posedge clk);
    #1;
    check("r_hold_done", 32'(tx_done), 32'd0);
    reset_n = 1'b0;
    wait_start(50, n);
    check("r_restart_gap", 32'(n), 32'd1);
    run_frame(8'hA5, 434, 1'b1, -1, "r");

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
